// File: rtl/adc_frame_align.sv
// Frame-lane alignment for ISERDES-based serial ADCs: drives bitslip until the frame word
// matches FRAME_PATTERN, then emits formatted, qualified per-channel samples.
module adc_frame_align #(
    parameter int                       NUM_CH        = 2,
    parameter int                       LANES_PER_CH  = 2,
    parameter int                       BITS_PER_LANE = 7,
    parameter int                       OUT_W         = 16,
    parameter logic [BITS_PER_LANE-1:0] FRAME_PATTERN = 7'b1111000,
    parameter int                       FORMAT        = 0,
    parameter int                       SLIP_WAIT     = 4,
    parameter int                       LOCK_COUNT    = 16,
    parameter int                       LOSS_COUNT    = 4,
    localparam int                      SAMPLE_W      = LANES_PER_CH * BITS_PER_LANE,
    localparam int                      SLIP_W        = $clog2(BITS_PER_LANE + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       resync,
    input  logic [BITS_PER_LANE-1:0]   deser_frame,
    input  logic [NUM_CH*SAMPLE_W-1:0] deser_data,
    output logic                       bitslip,
    output logic [NUM_CH*OUT_W-1:0]    data,
    output logic                       data_valid,
    output logic                       locked,
    output logic                       align_err,
    output logic [SLIP_W-1:0]          slip_count,
    output logic [7:0]                 lock_loss_cnt
);

    localparam int WAIT_W = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;
    localparam int VER_W  = $clog2(LOCK_COUNT + 1);
    localparam int LOSS_W = $clog2(LOSS_COUNT + 1);

    localparam logic [WAIT_W-1:0] WAIT_LOAD  = WAIT_W'(SLIP_WAIT);
    localparam logic [VER_W-1:0]  LOCK_CNT_V = VER_W'(LOCK_COUNT);
    localparam logic [LOSS_W-1:0] LOSS_CNT_V = LOSS_W'(LOSS_COUNT);
    localparam logic [SLIP_W-1:0] SLIP_WRAP  = SLIP_W'(BITS_PER_LANE);

    typedef enum logic [1:0] {
        ST_SEARCH    = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_VERIFY    = 2'd2,
        ST_LOCKED    = 2'd3
    } state_t;

    state_t                    state_reg, state_next;
    logic [WAIT_W-1:0]         wait_reg, wait_next;
    logic [VER_W-1:0]          ver_reg, ver_next;
    logic [LOSS_W-1:0]         miss_reg, miss_next;
    logic [SLIP_W-1:0]         slip_reg, slip_next;
    logic                      align_err_reg, align_err_next;
    logic                      locked_reg, locked_next;
    logic                      bitslip_reg, bitslip_next;
    logic [7:0]                loss_reg, loss_next;
    logic                      valid_reg, valid_next;
    logic [NUM_CH*OUT_W-1:0]   data_reg, data_next;
    logic [NUM_CH*OUT_W-1:0]   fmt_data;
    logic                      match;
    logic                      slip_req;
    logic [SLIP_W-1:0]         slip_inc;
    logic [VER_W-1:0]          ver_inc;
    logic [LOSS_W-1:0]         miss_inc;

    assign match    = (deser_frame == FRAME_PATTERN);
    assign slip_inc = slip_reg + 1'b1;
    assign ver_inc  = ver_reg + 1'b1;
    assign miss_inc = miss_reg + 1'b1;

    // Offset-binary to two's complement is just an MSB flip followed by sign extension.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [SAMPLE_W-1:0] sample;
            assign sample = deser_data[gi*SAMPLE_W +: SAMPLE_W];
            if (FORMAT == 1) begin : g_twos
                logic signed [SAMPLE_W-1:0] twos;
                assign twos = {~sample[SAMPLE_W-1], sample[SAMPLE_W-2:0]};
                assign fmt_data[gi*OUT_W +: OUT_W] = OUT_W'(twos);
            end else begin : g_raw
                assign fmt_data[gi*OUT_W +: OUT_W] = OUT_W'(sample);
            end
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        wait_next      = wait_reg;
        ver_next       = ver_reg;
        miss_next      = miss_reg;
        slip_next      = slip_reg;
        align_err_next = align_err_reg;
        locked_next    = locked_reg;
        bitslip_next   = 1'b0;
        loss_next      = loss_reg;
        valid_next     = 1'b0;
        data_next      = data_reg;
        slip_req       = 1'b0;

        case (state_reg)
            ST_SEARCH: begin
                if (!match) begin
                    slip_req = 1'b0 | 1'b1;
                end else if (LOCK_COUNT <= 1) begin
                    state_next  = ST_LOCKED;
                    locked_next = 1'b1;
                    miss_next   = '0;
                end else begin
                    state_next = ST_VERIFY;
                    ver_next   = VER_W'(1);
                end
            end
            ST_SLIP_WAIT: begin
                wait_next = wait_reg - 1'b1;
                if (wait_reg <= WAIT_W'(1)) begin
                    wait_next  = '0;
                    state_next = ST_SEARCH;
                end
            end
            ST_VERIFY: begin
                if (!match) begin
                    slip_req = 1'b1;
                end else if (ver_inc == LOCK_CNT_V) begin
                    state_next  = ST_LOCKED;
                    locked_next = 1'b1;
                    ver_next    = '0;
                    miss_next   = '0;
                end else begin
                    ver_next = ver_inc;
                end
            end
            default: begin
                if (match) begin
                    miss_next  = '0;
                    valid_next = 1'b1;
                    data_next  = fmt_data;
                end else if (miss_inc == LOSS_CNT_V) begin
                    // Lock loss restarts the search without slipping: the first frame seen
                    // in SEARCH may well still be aligned.
                    state_next  = ST_SEARCH;
                    locked_next = 1'b0;
                    miss_next   = '0;
                    slip_next   = '0;
                    if (loss_reg != 8'hFF) begin
                        loss_next = loss_reg + 1'b1;
                    end
                end else begin
                    miss_next = miss_inc;
                end
            end
        endcase

        if (slip_req) begin
            bitslip_next = 1'b1;
            wait_next    = WAIT_LOAD;
            state_next   = ST_SLIP_WAIT;
            ver_next     = '0;
            if (slip_inc == SLIP_WRAP) begin
                slip_next      = '0;
                align_err_next = 1'b1;
            end else begin
                slip_next = slip_inc;
            end
        end

        if (resync) begin
            state_next     = ST_SEARCH;
            wait_next      = '0;
            ver_next       = '0;
            miss_next      = '0;
            slip_next      = '0;
            align_err_next = 1'b0;
            locked_next    = 1'b0;
            bitslip_next   = 1'b0;
            loss_next      = loss_reg;
            valid_next     = 1'b0;
            data_next      = data_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_SEARCH;
            wait_reg      <= '0;
            ver_reg       <= '0;
            miss_reg      <= '0;
            slip_reg      <= '0;
            align_err_reg <= 1'b0;
            locked_reg    <= 1'b0;
            bitslip_reg   <= 1'b0;
            loss_reg      <= '0;
            valid_reg     <= 1'b0;
            data_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            wait_reg      <= wait_next;
            ver_reg       <= ver_next;
            miss_reg      <= miss_next;
            slip_reg      <= slip_next;
            align_err_reg <= align_err_next;
            locked_reg    <= locked_next;
            bitslip_reg   <= bitslip_next;
            loss_reg      <= loss_next;
            valid_reg     <= valid_next;
            data_reg      <= data_next;
        end
    end

    assign bitslip       = bitslip_reg;
    assign data          = data_reg;
    assign data_valid    = valid_reg;
    assign locked        = locked_reg;
    assign align_err     = align_err_reg;
    assign slip_count    = slip_reg;
    assign lock_loss_cnt = loss_reg;

endmodule

// File: doc/adc_frame_align.md
Name: adc_frame_align

Overview:
Parametrised frame-alignment and sample-capture block for multi-lane, multi-channel serial ADCs. It sits after the ISERDES-based deserializer and compares the deserialized frame-lane word against a known pattern. It drives the deserializer's bitslip through a search/verify/lock state machine with settle delay and lock-loss hysteresis. When locked, it emits formatted, qualified parallel samples per channel, plus lock status and diagnostic counters.

Parameters:
NUM_CH, 2, number of ADC channels
LANES_PER_CH, 2, serial data lanes per channel
BITS_PER_LANE, 7, deserialization factor per lane; SAMPLE_W = LANES_PER_CH*BITS_PER_LANE (derived, 14 by default)
OUT_W, 16, output width per channel; must be >= SAMPLE_W
FRAME_PATTERN, 7'b1111000, expected frame-lane word when aligned (width BITS_PER_LANE)
FORMAT, 0, 0 = raw zero-extend; 1 = offset-binary to two's complement (invert MSB, sign-extend)
SLIP_WAIT, 4, cycles to wait after a bitslip pulse before re-checking
LOCK_COUNT, 16, consecutive matching frames required to declare lock
LOSS_COUNT, 4, consecutive mismatching frames in LOCKED that drop lock

Ports:
clk  in  1  deserializer divided clock; the only clock
reset  in  1  synchronous, active-high reset
resync  in  1  pulse; forces re-alignment
deser_frame  in  BITS_PER_LANE  deserialized frame-lane word
deser_data  in  NUM_CH*SAMPLE_W  channel c occupies [c*SAMPLE_W +: SAMPLE_W]
bitslip  out  1  one-cycle pulse to the deserializer BITSLIP input
data  out  NUM_CH*OUT_W  formatted samples; channel c at [c*OUT_W +: OUT_W]
data_valid  out  1  data qualifier
locked  out  1  alignment locked
align_err  out  1  sticky: a full slip cycle passed without a match
slip_count  out  clog2(BITS_PER_LANE+1)  bitslips issued since the last search start
lock_loss_cnt  out  8  saturating count of lock losses

Behaviour:
- Single clock domain. All outputs are registered. Reset is synchronous and active-high; reset wins over every other input.
- Reset values: bitslip 0, data 0, data_valid 0, locked 0, align_err 0, slip_count 0, lock_loss_cnt 0. State is SEARCH and all internal counters are 0.
- match = (deser_frame == FRAME_PATTERN), evaluated every cycle.
- SEARCH:
  - match: go to VERIFY with verify count 1.
  - mismatch: pulse bitslip for 1 cycle, increment slip_count, load the wait counter with SLIP_WAIT, go to SLIP_WAIT.
  - If the increment makes slip_count equal BITS_PER_LANE: set align_err and wrap slip_count to 0.
- SLIP_WAIT: decrement the wait counter each cycle; no compare. When it reaches 0, go to SEARCH. Consecutive bitslip pulses are therefore spaced SLIP_WAIT+1 cycles apart.
- VERIFY:
  - match: increment verify count. When it reaches LOCK_COUNT, go to LOCKED and assert locked on the next cycle.
  - mismatch: same action as a SEARCH mismatch (bitslip pulse, go to SLIP_WAIT).
- LOCKED:
  - match: clear the mismatch counter.
  - mismatch: increment the mismatch counter. When it reaches LOSS_COUNT, deassert locked, increment lock_loss_cnt (saturate at 255), clear slip_count, go to SEARCH. No bitslip is issued on the transition.
- Data path: 1-cycle latency. data is registered from deser_data every cycle in which the current state is LOCKED and match=1. data_valid is registered from (state==LOCKED && match); otherwise data holds its value and data_valid=0.
- Format rule, per channel:
  - FORMAT=0: data = {zeros, sample}.
  - FORMAT=1: t = {~sample[SAMPLE_W-1], sample[SAMPLE_W-2:0]}; data = sign-extend(t) to OUT_W.
- resync=1 (and reset=0): next state SEARCH; locked, data_valid, align_err, slip_count and internal counters cleared; lock_loss_cnt retained; no bitslip that cycle. resync overrides a simultaneous lock completion or loss (no lock_loss_cnt increment).
- bitslip is never asserted on two consecutive cycles and never while LOCKED.

Test Plan:
1. Defaults; deser_frame held at 7'h78 from reset release -> no bitslip. locked rises the cycle after the 16th frame. First data_valid follows frame 17, one cycle later. Channel 0 sample 14'h2ABC -> data[15:0]=16'h2ABC.
2. Bench model rotates the frame lane, starting misaligned by 3 bits -> exactly 3 bitslip pulses, each 5 cycles apart. slip_count=3, then locked after 16 matches, align_err=0.
3. deser_frame held at 7'h00 -> bitslip every 5 cycles. After the 7th pulse, align_err=1 and slip_count=0. locked stays 0 and data_valid stays 0.
4. Locked, then 3 bad frames then good frames -> locked stays 1, data_valid low for exactly 3 cycles. Then 4 bad frames -> locked falls, lock_loss_cnt=1, and relock occurs with no bitslip.
5. FORMAT=1, locked, samples 14'h2000 / 14'h0000 / 14'h3FFF -> data 16'h0000 / 16'hE000 / 16'h1FFF.
6. resync while locked -> next cycle locked=0, state SEARCH, lock_loss_cnt unchanged. reset asserted mid-SLIP_WAIT -> all outputs at reset values the next cycle.
